timer_alarm: RTL and testbench



---
 rtl/timer_alarm_pkg.sv | 22 ++
 rtl/timer_alarm.sv | 171 +++++++++++++++++
 tb/tb_timer_alarm.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_alarm_pkg.sv
// -----------------------------------------------------------------------------
// timer_alarm_pkg
//
// Purpose : shared definitions for the compare/alarm stage that sits next to
//           the 64-bit timer core: alarm state encodings and default widths.
//
// Contents:
//   alarm_state_e          - two-state alarm FSM encoding (IDLE = 0, ARMED = 1)
//   ALARM_DATA_W_DEFAULT   - default CPU word width (timer is twice this)
//   ALARM_CNT_W_DEFAULT    - default width of the match counter
// -----------------------------------------------------------------------------
package timer_alarm_pkg;

    typedef enum logic {
        ALARM_IDLE  = 1'b0,
        ALARM_ARMED = 1'b1
    } alarm_state_e;

    localparam int unsigned ALARM_DATA_W_DEFAULT = 32;
    localparam int unsigned ALARM_CNT_W_DEFAULT  = 16;

endpackage : timer_alarm_pkg

// File: rtl/timer_alarm.sv
// -----------------------------------------------------------------------------
// timer_alarm
//
// Purpose : compare/alarm stage fed by the free-running timer count. Raises a
//           sticky interrupt when the count equals a programmed target. With a
//           non-zero period the target is advanced by the period on every match
//           (periodic mode); with period 0 the alarm disarms after one match
//           (one-shot mode). Matches since the last arm are counted (saturating)
//           and a sticky flag records matches that land while irq is pending.
//
// Parameters:
//   DATA_W      CPU word width; timer/compare width is 2*DATA_W
//   CNT_W       width of the match counter
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   timer_value  in   current timer count (2*DATA_W)
//   timer_en     in   timer counting enable; matches only evaluated when 1
//   cmp_wr       in   pulse: load cmp_value -> target, period -> period register
//   cmp_value    in   absolute match target (2*DATA_W)
//   period       in   periodic reload increment; 0 selects one-shot
//   arm          in   pulse: enter ARMED, clear fired_cnt and missed
//   disarm       in   pulse: enter IDLE
//   irq_ack      in   pulse: clear irq
//   irq          out  sticky alarm interrupt
//   armed        out  1 while in ARMED
//   fired_cnt    out  matches since last arm, saturating at all-ones
//   missed       out  sticky overrun flag
// -----------------------------------------------------------------------------
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int unsigned DATA_W = ALARM_DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = ALARM_CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*DATA_W-1:0]   timer_value,
    input  logic                  timer_en,
    input  logic                  cmp_wr,
    input  logic [2*DATA_W-1:0]   cmp_value,
    input  logic [2*DATA_W-1:0]   period,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic                  irq_ack,
    output logic                  irq,
    output logic                  armed,
    output logic [CNT_W-1:0]      fired_cnt,
    output logic                  missed
);

    localparam int unsigned TW = 2 * DATA_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    alarm_state_e     state_q,     state_d;
    logic [TW-1:0]    target_q,    target_d;
    logic [TW-1:0]    period_q,    period_d;
    logic             irq_q,       irq_d;
    logic [CNT_W-1:0] fired_cnt_q, fired_cnt_d;
    logic             missed_q,    missed_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          arm_eff;     // arm that is not overridden by disarm
    logic          match;       // raw equality match while armed and counting
    logic          hit;         // match that is allowed to take effect
    logic          periodic;    // non-zero period selects periodic re-arm
    logic [TW-1:0] target_next; // target advanced by one period, wraps mod 2^TW
    logic          cnt_full;    // counter has reached all-ones

    always_comb begin
        arm_eff     = arm & ~disarm;
        // Equality only: a target the count has already passed is reached
        // again only after the counter wraps, which keeps the compare wrap-safe.
        match       = (state_q == ALARM_ARMED) & timer_en & (timer_value == target_q);
        // arm/disarm take priority and suppress any match in their cycle.
        hit         = match & ~arm & ~disarm;
        periodic    = (period_q != '0);
        target_next = target_q + period_q;
        cnt_full    = &fired_cnt_q;
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        // Defaults: hold everything.
        state_d     = state_q;
        target_d    = target_q;
        period_d    = period_q;
        irq_d       = irq_q;
        fired_cnt_d = fired_cnt_q;
        missed_d    = missed_q;

        // FSM: disarm > arm > one-shot hit.
        if (disarm) begin
            state_d = ALARM_IDLE;
        end else if (arm) begin
            state_d = ALARM_ARMED;
        end else if (hit && !periodic) begin
            state_d = ALARM_IDLE;
        end

        // Target: periodic advance, but a register write in the same cycle
        // wins. The compare this cycle already used the old target_q.
        if (hit && periodic) begin
            target_d = target_next;
        end
        if (cmp_wr) begin
            target_d = cmp_value;
            period_d = period;
        end

        // Interrupt: set wins over a simultaneous acknowledge.
        if (hit) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end

        // Match counter and overrun flag. A (re)arm clears both; disarm
        // leaves them untouched so software can still read the history.
        if (arm_eff) begin
            fired_cnt_d = '0;
            missed_d    = 1'b0;
        end else if (hit) begin
            if (!cnt_full) begin
                fired_cnt_d = fired_cnt_q + CNT_W'(1);
            end
            // An acknowledge in the same cycle means the previous interrupt
            // was serviced in time, so this hit is not an overrun.
            if (irq_q && !irq_ack) begin
                missed_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ALARM_IDLE;
            target_q    <= '0;
            period_q    <= '0;
            irq_q       <= 1'b0;
            fired_cnt_q <= '0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            period_q    <= period_d;
            irq_q       <= irq_d;
            fired_cnt_q <= fired_cnt_d;
            missed_q    <= missed_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign irq       = irq_q;
    assign armed     = (state_q == ALARM_ARMED);
    assign fired_cnt = fired_cnt_q;
    assign missed    = missed_q;

endmodule : timer_alarm

// File: tb/tb_timer_alarm.sv
// -----------------------------------------------------------------------------
// tb_timer_alarm
//
// Directed bench for timer_alarm. The driver applies one cycle of inputs at a
// time and pushes the hand-computed outputs expected after that clock edge into
// a queue tagged with the cycle in which they must appear. A separate monitor
// pops entries for the current cycle on the falling edge and compares.
// A second instance with CNT_W = 4 shares all inputs for the saturation case.
// -----------------------------------------------------------------------------
module tb_timer_alarm;

    typedef struct {
        int          cyc;
        string       name;
        logic [4:0]  mask;   // 0 irq, 1 armed, 2 fired_cnt, 3 missed, 4 fired_cnt (CNT_W=4)
        logic        irq;
        logic        armed;
        logic [15:0] cnt;
        logic        missed;
        logic [3:0]  cnt4;
    } exp_t;

    localparam logic [4:0] M_ALL  = 5'b01111;
    localparam logic [4:0] M_ALL4 = 5'b11111;
    localparam logic [4:0] M_IA   = 5'b00011;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] timer_value;
    logic        timer_en;
    logic        cmp_wr;
    logic [63:0] cmp_value;
    logic [63:0] period;
    logic        arm;
    logic        disarm;
    logic        irq_ack;

    logic        irq,  armed,  missed;
    logic [15:0] fired_cnt;
    logic        irq4, armed4, missed4;
    logic [3:0]  fired_cnt4;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    timer_alarm #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .timer_value(timer_value), .timer_en(timer_en),
        .cmp_wr(cmp_wr), .cmp_value(cmp_value), .period(period), .arm(arm),
        .disarm(disarm), .irq_ack(irq_ack), .irq(irq), .armed(armed),
        .fired_cnt(fired_cnt), .missed(missed)
    );

    timer_alarm #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .timer_value(timer_value), .timer_en(timer_en),
        .cmp_wr(cmp_wr), .cmp_value(cmp_value), .period(period), .arm(arm),
        .disarm(disarm), .irq_ack(irq_ack), .irq(irq4), .armed(armed4),
        .fired_cnt(fired_cnt4), .missed(missed4)
    );

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic cmp1(input string nm, input string fld, input logic [15:0] act,
                        input logic [15:0] req);
        checks++;
        if (act !== req)
            $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, fld, act, req, cyc);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                $display("FAIL %s: expectation for cycle %0d was not checked in time (now %0d)",
                         e.name, e.cyc, cyc);
            end else begin
                if (e.mask[0]) cmp1(e.name, "irq",       {15'd0, irq},       {15'd0, e.irq});
                if (e.mask[1]) cmp1(e.name, "armed",     {15'd0, armed},     {15'd0, e.armed});
                if (e.mask[2]) cmp1(e.name, "fired_cnt", fired_cnt,          e.cnt);
                if (e.mask[3]) cmp1(e.name, "missed",    {15'd0, missed},    {15'd0, e.missed});
                if (e.mask[4]) cmp1(e.name, "fired_cnt4",{12'd0, fired_cnt4},{12'd0, e.cnt4});
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    // Move to just after the falling edge and drop all single-cycle pulses.
    task automatic next_cycle();
        @(negedge clk);
        #1;
        rst     = 1'b0;
        cmp_wr  = 1'b0;
        arm     = 1'b0;
        disarm  = 1'b0;
        irq_ack = 1'b0;
    endtask

    // Expected outputs after the upcoming rising edge.
    task automatic expect_o(input string nm, input logic [4:0] m, input logic i,
                            input logic a, input logic [15:0] c, input logic ms,
                            input logic [3:0] c4);
        exp_t e;
        e.cyc    = cyc + 1;
        e.name   = nm;
        e.mask   = m;
        e.irq    = i;
        e.armed  = a;
        e.cnt    = c;
        e.missed = ms;
        e.cnt4   = c4;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [63:0] wrap_tv  [7];
    logic        wrap_irq [7];
    logic [15:0] wrap_cnt [7];

    initial begin
        rst = 1'b1; timer_value = '0; timer_en = 1'b0; cmp_wr = 1'b0;
        cmp_value = '0; period = '0; arm = 1'b0; disarm = 1'b0; irq_ack = 1'b0;

        wrap_tv[0] = 64'hFFFF_FFFF_FFFF_FFFD; wrap_irq[0] = 1'b0; wrap_cnt[0] = 16'd0;
        wrap_tv[1] = 64'hFFFF_FFFF_FFFF_FFFE; wrap_irq[1] = 1'b1; wrap_cnt[1] = 16'd1;
        wrap_tv[2] = 64'hFFFF_FFFF_FFFF_FFFF; wrap_irq[2] = 1'b0; wrap_cnt[2] = 16'd1;
        wrap_tv[3] = 64'd0;                   wrap_irq[3] = 1'b0; wrap_cnt[3] = 16'd1;
        wrap_tv[4] = 64'd1;                   wrap_irq[4] = 1'b0; wrap_cnt[4] = 16'd1;
        wrap_tv[5] = 64'd2;                   wrap_irq[5] = 1'b1; wrap_cnt[5] = 16'd2;
        wrap_tv[6] = 64'd3;                   wrap_irq[6] = 1'b0; wrap_cnt[6] = 16'd2;

        @(posedge clk);

        // Reset state
        next_cycle(); rst = 1'b1;
        expect_o("reset", M_ALL4, 0, 0, 16'd0, 0, 4'd0);

        // One-shot: target 100, period 0
        next_cycle(); cmp_wr = 1'b1; cmp_value = 64'd100; period = 64'd0;
        next_cycle(); arm = 1'b1; timer_en = 1'b1; timer_value = 64'd0;
        expect_o("oneshot_arm", M_ALL, 0, 1, 16'd0, 0, 4'd0);
        for (int t = 1; t <= 300; t++) begin
            next_cycle(); timer_value = 64'(t);
            expect_o("oneshot", M_ALL, (t >= 100), (t < 100),
                     (t >= 100) ? 16'd1 : 16'd0, 0, 4'd0);
        end
        next_cycle(); irq_ack = 1'b1;
        expect_o("oneshot_ack", M_ALL, 0, 0, 16'd1, 0, 4'd0);

        // Periodic: target 10, period 5, acknowledge each interrupt
        next_cycle(); cmp_wr = 1'b1; cmp_value = 64'd10; period = 64'd5;
        next_cycle(); arm = 1'b1; timer_value = 64'd0;
        expect_o("periodic_arm", M_ALL, 0, 1, 16'd0, 0, 4'd0);
        for (int t = 1; t <= 27; t++) begin
            logic        h;
            logic        prev_h;
            logic [15:0] c;
            h      = (t >= 10) && (t <= 25) && (t % 5 == 0);
            prev_h = (t >= 11) && (t <= 26) && ((t - 1) % 5 == 0);
            c      = (t >= 25) ? 16'd4 : (t >= 20) ? 16'd3 : (t >= 15) ? 16'd2 :
                     (t >= 10) ? 16'd1 : 16'd0;
            next_cycle(); timer_value = 64'(t); irq_ack = prev_h;
            expect_o("periodic", M_ALL, h, 1, c, 0, 4'd0);
        end

        // Overrun with period 1
        next_cycle(); cmp_wr = 1'b1; cmp_value = 64'd50; period = 64'd1; timer_value = 64'd40;
        next_cycle(); arm = 1'b1; timer_value = 64'd49;
        expect_o("ovr_arm", M_ALL, 0, 1, 16'd0, 0, 4'd0);
        next_cycle(); timer_value = 64'd50;
        expect_o("ovr_first_hit", M_ALL, 1, 1, 16'd1, 0, 4'd0);
        next_cycle(); timer_value = 64'd51;
        expect_o("ovr_second_hit", M_ALL, 1, 1, 16'd2, 1, 4'd0);
        next_cycle(); arm = 1'b1; timer_en = 1'b0; timer_value = 64'd52;
        expect_o("rearm_keeps_irq", M_ALL, 1, 1, 16'd0, 0, 4'd0);
        next_cycle(); timer_en = 1'b1; timer_value = 64'd52; irq_ack = 1'b1;
        expect_o("ack_with_hit", M_ALL, 1, 1, 16'd1, 0, 4'd0);
        next_cycle(); timer_value = 64'd53;
        expect_o("ovr_after_ack_hit", M_ALL, 1, 1, 16'd2, 1, 4'd0);

        // Stall: value equals target (54) while timer disabled
        next_cycle(); timer_en = 1'b0; timer_value = 64'd54; irq_ack = 1'b1;
        expect_o("stall_ack", M_ALL, 0, 1, 16'd2, 1, 4'd0);
        next_cycle(); timer_value = 64'd54;
        expect_o("stall_no_hit", M_ALL, 0, 1, 16'd2, 1, 4'd0);

        // arm and disarm together: disarm wins, no hit
        next_cycle(); timer_en = 1'b1; arm = 1'b1; disarm = 1'b1;
        expect_o("arm_disarm", M_IA, 0, 0, 16'd0, 0, 4'd0);
        next_cycle();
        expect_o("idle_no_hit", M_IA, 0, 0, 16'd0, 0, 4'd0);

        // Reset while armed with irq pending
        next_cycle(); arm = 1'b1;
        expect_o("rst_pre_arm", M_ALL, 0, 1, 16'd0, 0, 4'd0);
        next_cycle();
        expect_o("rst_pre_hit", M_ALL, 1, 1, 16'd1, 0, 4'd0);
        next_cycle(); timer_value = 64'd55; rst = 1'b1; arm = 1'b1;
        expect_o("rst_mid_op", M_ALL4, 0, 0, 16'd0, 0, 4'd0);
        next_cycle(); arm = 1'b1; timer_value = 64'd0;
        expect_o("post_rst_arm", M_ALL, 0, 1, 16'd0, 0, 4'd0);
        next_cycle();
        expect_o("post_rst_target0", M_ALL, 1, 0, 16'd1, 0, 4'd0);

        // Wrap: target 2^64-2, period 4
        next_cycle(); irq_ack = 1'b1; cmp_wr = 1'b1;
        cmp_value = 64'hFFFF_FFFF_FFFF_FFFE; period = 64'd4; timer_value = 64'd1;
        expect_o("wrap_setup", M_IA, 0, 0, 16'd0, 0, 4'd0);
        next_cycle(); arm = 1'b1; timer_value = 64'hFFFF_FFFF_FFFF_FFFC;
        expect_o("wrap_arm", M_ALL, 0, 1, 16'd0, 0, 4'd0);
        for (int k = 0; k < 7; k++) begin
            next_cycle(); timer_value = wrap_tv[k];
            irq_ack = (k == 2) || (k == 6);
            expect_o("wrap", M_ALL, wrap_irq[k], 1, wrap_cnt[k], 0, 4'd0);
        end

        // cmp_wr coinciding with a periodic hit at 6: written target wins
        next_cycle(); timer_value = 64'd6; cmp_wr = 1'b1; cmp_value = 64'd20; period = 64'd4;
        expect_o("cmpwr_hit", M_ALL, 1, 1, 16'd3, 0, 4'd0);
        next_cycle(); timer_value = 64'd7; irq_ack = 1'b1;
        expect_o("cmpwr_ack", M_ALL, 0, 1, 16'd3, 0, 4'd0);
        next_cycle(); timer_value = 64'd10;
        expect_o("cmpwr_no_old_hit", M_ALL, 0, 1, 16'd3, 0, 4'd0);
        next_cycle(); timer_value = 64'd20;
        expect_o("cmpwr_new_hit", M_ALL, 1, 1, 16'd4, 0, 4'd0);

        // Saturation: period 1, 20 consecutive hits
        next_cycle(); irq_ack = 1'b1; cmp_wr = 1'b1; cmp_value = 64'd200; period = 64'd1;
        timer_value = 64'd150;
        next_cycle(); arm = 1'b1; timer_value = 64'd199;
        expect_o("sat_arm", M_ALL4, 0, 1, 16'd0, 0, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            next_cycle(); timer_value = 64'(199 + k);
            expect_o("saturate", M_ALL4, 1, 1, 16'(k), (k >= 2),
                     (k > 15) ? 4'd15 : 4'(k));
        end

        // Drain outstanding expectations
        next_cycle(); timer_en = 1'b0;
        next_cycle();
        next_cycle();
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_timer_alarm
